// File: rtl/up_pkg.sv
// up_pkg: shared widths and ALU opcodes for the 4-bit microprocessor
package up_pkg;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 12;
  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_CMP    = 3'b001;
  localparam logic [2:0] ALU_PASS_B = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_ADD    = 3'b100;
  localparam logic [2:0] ALU_NAND   = 3'b101;
endpackage

// File: rtl/alu_4b.sv
// alu_4b: combinational 4-bit ALU producing result, carry and zero
module alu_4b
  import up_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);
  logic [DATA_W:0] add_w;
  logic [DATA_W:0] sub_w;
  // 5-bit sums; for subtract/compare the carry out means "no borrow"
  always_comb begin
    add_w  = {1'b0, a} + {1'b0, b};
    sub_w  = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
    result = (op == ALU_ADD) ? add_w[DATA_W-1:0] :
             (op == ALU_SUB || op == ALU_CMP) ? sub_w[DATA_W-1:0] :
             (op == ALU_PASS_A) ? a :
             (op == ALU_PASS_B) ? b :
             (op == ALU_NAND) ? ~(a & b) : '0;
    carry  = (op == ALU_ADD) ? add_w[DATA_W] :
             (op == ALU_SUB || op == ALU_CMP) ? sub_w[DATA_W] : 1'b0;
    zero   = (result == '0);
  end
endmodule

// File: rtl/execute_unit.sv
// execute_unit: accumulator, flags, data RAM, I/O ports and bus mux; INPUT_SYNC_EN adds a 2-flop pushbutton synchronizer
module execute_unit
  import up_pkg::*;
#(
  parameter int RAM_DEPTH = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              phase,
  input  logic              loadA,
  input  logic              loadFlags,
  input  logic [2:0]        opALU,
  input  logic              cs,
  input  logic              we,
  input  logic              eoALU,
  input  logic              oeIn,
  input  logic              oeOprnd,
  input  logic              loadOut,
  input  logic [DATA_W-1:0] oprnd,
  input  logic [ADDR_W-1:0] address_RAM,
  input  logic [DATA_W-1:0] pushbuttons,
  output logic [DATA_W-1:0] data_bus,
  output logic [DATA_W-1:0] accu,
  output logic [DATA_W-1:0] FF_out,
  output logic              c_flag,
  output logic              z_flag
);
  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [DATA_W-1:0] accu_q, accu_d, out_q, out_d, src, pb, alu_res;
  logic              c_q, c_d, z_q, z_d, alu_c, alu_z;

  alu_4b u_alu (.a(accu_q), .b(src), .op(opALU), .result(alu_res), .carry(alu_c), .zero(alu_z));

`ifdef INPUT_SYNC_EN
  logic [DATA_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  // two-stage synchronizer for the asynchronous pushbuttons
  always_comb begin
    sync1_d = pushbuttons;
    sync2_d = sync1_q;
  end
  // synchronizer flops, cleared by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
  assign pb = sync2_q;
`else
  assign pb = pushbuttons;
`endif

  // source mux feeds the ALU B operand; the ALU result is never fed back, so no loop
  always_comb begin
    src      = oeOprnd ? oprnd : oeIn ? pb : (cs & ~we) ? mem[address_RAM] : '0;
    data_bus = eoALU ? alu_res : src;
    accu_d   = (phase & loadA) ? alu_res : accu_q;
    c_d      = (phase & loadFlags) ? alu_c : c_q;
    z_d      = (phase & loadFlags) ? alu_z : z_q;
    out_d    = (phase & loadOut) ? data_bus : out_q;
  end

  // architectural registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      accu_q <= '0;
      out_q  <= '0;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
    end else begin
      accu_q <= accu_d;
      out_q  <= out_d;
      c_q    <= c_d;
      z_q    <= z_d;
    end
  end

  // data RAM is not reset; a store coinciding with reset is dropped
  always_ff @(posedge clock) begin
    if (reset && phase && cs && we) mem[address_RAM] <= data_bus;
  end

  assign accu   = accu_q;
  assign FF_out = out_q;
  assign c_flag = c_q;
  assign z_flag = z_q;
endmodule

// File: doc/execute_unit.md
# execute_unit

Execute stage of the 4-bit microprocessor: consumes the per-phase control word from the instruction decoder plus the latched operand, and performs the data-side work. It holds the accumulator, the carry/zero flags, the 4096×4 data RAM, the input port and the latched output port, and drives the shared 4-bit data bus. Its `c_flag`/`z_flag` outputs feed back into the decoder for conditional jumps.

## Interface

- `RAM_DEPTH`, 4096: data RAM words; the address is the full 12-bit `address_RAM`.
- `clock` in 1: single system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; low clears all registers immediately.
- `phase` in 1: fetch/execute phase. All writes are enabled only when `phase`=1.
- `loadA` in 1: load accumulator from ALU result.
- `loadFlags` in 1: load C/Z from ALU.
- `opALU` in 3: ALU operation select.
- `cs` in 1: RAM chip select.
- `we` in 1: RAM write enable; when low with `cs`=1, the RAM is read.
- `eoALU` in 1: ALU result drives the data bus.
- `oeIn` in 1: `pushbuttons` drive the bus.
- `oeOprnd` in 1: `oprnd` drives the bus.
- `loadOut` in 1: latch the bus into `FF_out`.
- `oprnd` in 4: immediate operand from fetch.
- `address_RAM` in 12: `{oprnd, program_byte}`.
- `pushbuttons` in 4: raw input port.
- `data_bus` out 4: resolved bus value.
- `accu` out 4: accumulator.
- `FF_out` out 4: output port register.
- `c_flag`, `z_flag` out 1: flags.

## Operation

- Source bus (`src`): priority mux with the order `oeOprnd` > `oeIn` > RAM read (`cs & ~we`) > 4'h0. There are no tri-states.
- `data_bus` = `eoALU` ? `alu_result` : `src`. The ALU B operand is always `src`, never `data_bus`, so there is no combinational loop.
- ALU operations, with A=`accu` and B=`src`:
  - 000 PASS_A: result A.
  - 001 CMP: result A−B. Only the flags are meaningful; the decoder does not assert `loadA`.
  - 010 PASS_B: result B.
  - 011 SUB: result A+~B+1.
  - 100 ADD: result A+B.
  - 101 NAND: result ~(A&B).
  - 110 and 111: result 4'h0, C=0.
- Width rules: sums are computed 5 bits wide. C is bit 4 for ADD, SUB and CMP; for SUB/CMP, C=1 means no borrow (A≥B unsigned). C=0 for the logical and pass operations. Z = (result[3:0]==0).
- Writes, on the rising edge with `phase`=1:
  - `loadA`: `accu` <= result.
  - `loadFlags`: {C,Z} <= ALU flags.
  - `cs & we`: RAM[`address_RAM`] <= `data_bus`.
  - `loadOut`: `FF_out` <= `data_bus`.
- Writes are independent and may coincide in one cycle. Every write samples the pre-edge values, so a simultaneous `loadA` and store writes the new result to the RAM, not the old `accu`.
- `phase`=0: no register or RAM changes. The bus is still driven combinationally.
- RAM reads are asynchronous. RAM contents are not reset and are X until written.

## Timing

- Reset values: `accu`=0, `c_flag`=0, `z_flag`=0, `FF_out`=0. `data_bus` follows its inputs; it is 0 when all enables are low.
- Results are visible on the outputs one clock after the execute-phase edge.
- The flags updated at the execute edge are valid during the next fetch and execute phases, in time for the decoder's conditional branch.
- Reset asserted mid-execute aborts that cycle's writes. A RAM write on the same edge as reset assertion is not performed.
- Decode-to-bus is a purely combinational path within one cycle.

## Configuration

- `INPUT_SYNC_EN`:
  - Defined: `pushbuttons` pass through a 2-flop synchronizer (reset to 0) before the bus mux. Input latency is 2 clocks.
  - Undefined: `pushbuttons` go to the mux directly, with 0 latency.

## Structure

- Shared package `up_pkg`:
  - ALU opcode constants (`ALU_PASS_A` … `ALU_NAND`).
  - The data width (4) and address width (12).
- Sub-module `alu_4b`: combinational, with inputs A, B and op; outputs result, carry and zero.
- RAM, flags, accumulator, output register and bus mux all live in `execute_unit`.

## Test plan

- Reset low with `accu` preloaded at 4'h9 → `accu`, `FF_out`, `c_flag`, `z_flag` all 0 immediately, without waiting for a clock.
- `oeOprnd`, `oprnd`=4'h7, `opALU`=PASS_B, `loadA`, `phase`=1 → `accu`=7 after the edge. Same control with `phase`=0 → `accu` unchanged.
- `accu`=4'hC, `oprnd`=4'h5, ADD, `loadA`+`loadFlags` → `accu`=4'h1, C=1, Z=0. `accu`=4'h3, `oprnd`=3, CMP, `loadFlags` only → C=1, Z=1, `accu` still 3.
- `accu`=4'hA, `eoALU`, PASS_A, `cs`=1, `we`=1, `address_RAM`=12'h3F2 → RAM[3F2]=A. Next cycle: `cs`=1, `we`=0, PASS_B, `loadA` at `accu`=0 → `accu`=A.
- `oeIn` with `pushbuttons`=4'h6 and `loadOut` → `FF_out`=6 one edge later, or three edges later with `INPUT_SYNC_EN`. `oeIn` and `oeOprnd` both high → bus = `oprnd`.
- `accu`=2, `oprnd`=3, SUB, `loadA`+`loadFlags`+`eoALU`+`cs`/`we`, address 0 → `accu`=4'hF, C=0, RAM[0]=4'hF.
